// File: rtl/huffman_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : huffman_stream_decoder
// Brief    : Table-programmable Huffman decoder, bit stream in, packed
//            fixed-width symbol words out, valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
module huffman_stream_decoder #(
    parameter int SYM_W   = 4,
    parameter int MAX_LEN = 8,
    parameter int IN_W    = 32,
    parameter int LANES   = 8,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cfg_we,
    input  logic [SYM_W-1:0]             cfg_addr,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [MAX_LEN-1:0]           cfg_code,
    input  logic                         start,
    input  logic [CNT_W-1:0]             sym_total,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [LANES*SYM_W-1:0]       out_data,
    output logic [$clog2(LANES+1)-1:0]   out_lanes,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int c_ENTRIES = 1 << SYM_W;
    localparam int c_LEN_W   = $clog2(MAX_LEN + 1);
    localparam int c_LANE_W  = $clog2(LANES + 1);
    localparam int c_BUF_W   = 2 * IN_W;
    localparam int c_BCNT_W  = $clog2(c_BUF_W + 1);
    localparam int c_PACK_W  = LANES * SYM_W;
    localparam logic [MAX_LEN-1:0] c_ONES = {MAX_LEN{1'b1}};

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;
    localparam logic [1:0] c_S_ERROR = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [c_LEN_W-1:0]    r_tbl_len  [c_ENTRIES];
    logic [MAX_LEN-1:0]    r_tbl_code [c_ENTRIES];
    logic [c_BUF_W-1:0]    r_buf;
    logic [c_BCNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]      r_sym_total;
    logic [CNT_W-1:0]      r_decoded;
    logic [c_PACK_W-1:0]   r_pack;
    logic [c_LANE_W-1:0]   r_pack_cnt;
    logic [c_PACK_W-1:0]   r_out_data;
    logic [c_LANE_W-1:0]   r_out_lanes;
    logic                  r_out_last;
    logic                  r_out_valid;
    logic                  r_done;
    logic                  r_err;

    logic                  w_match;
    logic [SYM_W-1:0]      w_sym;
    logic [c_LEN_W-1:0]    w_len;
    logic [IN_W-1:0]       w_rev;
    logic                  w_in_ready;
    logic                  w_take;
    logic                  w_pack_full;
    logic                  w_out_free;
    logic                  w_load;
    logic                  w_dec;
    logic                  w_err_hit;
    logic                  w_fin;
    logic                  w_start;
    logic [c_LEN_W-1:0]    w_shift_len;
    logic [c_BCNT_W-1:0]   w_cnt_sh;
    logic [c_BUF_W-1:0]    w_buf_sh;
    logic [c_BUF_W-1:0]    w_app;
    logic [c_BUF_W-1:0]    w_buf_nx;
    logic [c_BCNT_W-1:0]   w_cnt_nx;
    logic [c_PACK_W-1:0]   w_pack_nx;
    logic [c_LANE_W-1:0]   w_pack_cnt_nx;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_match = 1'b0;
        w_sym   = '0;
        w_len   = '0;
        for (int k = c_ENTRIES - 1; k >= 0; k--) begin
            if ((r_tbl_len[k] != '0) &&
                (c_BCNT_W'(r_tbl_len[k]) <= r_cnt) &&
                (((r_buf[MAX_LEN-1:0] ^ r_tbl_code[k]) & ~(c_ONES << r_tbl_len[k])) == '0)) begin
                w_match = 1'b1;
                w_sym   = SYM_W'(k);
                w_len   = r_tbl_len[k];
            end
        end
    end

    always_comb begin
        w_rev = '0;
        for (int j = 0; j < IN_W; j++) begin
            w_rev[j] = in_data[IN_W-1-j];
        end
    end

    assign w_in_ready  = (r_state == c_S_RUN) && (r_cnt <= c_BCNT_W'(c_BUF_W - IN_W));
    assign w_take      = in_valid && w_in_ready;
    assign w_pack_full = (r_pack_cnt == c_LANE_W'(LANES));
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_load      = w_out_free &&
                         (((r_state == c_S_RUN) && w_pack_full) ||
                          ((r_state == c_S_FLUSH) && (r_pack_cnt != '0)));
    assign w_dec       = (r_state == c_S_RUN) && w_match && (r_decoded < r_sym_total) &&
                         (!w_pack_full || w_load);
    assign w_err_hit   = (r_state == c_S_RUN) && !w_match && (r_cnt >= c_BCNT_W'(MAX_LEN));
    assign w_fin       = (r_state == c_S_FLUSH) && r_out_valid && out_ready && r_out_last;
    assign w_start     = start && ((r_state == c_S_IDLE) || (r_state == c_S_ERROR));

    // Consume first, then append the new word right behind the surviving bits.
    assign w_shift_len = w_dec ? w_len : '0;
    assign w_cnt_sh    = r_cnt - c_BCNT_W'(w_shift_len);
    assign w_buf_sh    = r_buf >> w_shift_len;
    assign w_app       = c_BUF_W'(w_rev) << w_cnt_sh;
    assign w_buf_nx    = w_take ? (w_buf_sh | w_app) : w_buf_sh;
    assign w_cnt_nx    = w_take ? (w_cnt_sh + c_BCNT_W'(IN_W)) : w_cnt_sh;

    always_comb begin
        w_pack_nx     = r_pack;
        w_pack_cnt_nx = r_pack_cnt;
        if (w_load) begin
            w_pack_nx     = '0;
            w_pack_cnt_nx = '0;
        end
        if (w_dec) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_pack_cnt_nx == c_LANE_W'(l)) begin
                    w_pack_nx[l*SYM_W +: SYM_W] = w_sym;
                end
            end
            w_pack_cnt_nx = w_pack_cnt_nx + c_LANE_W'(1);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_S_IDLE, c_S_ERROR: begin
                if (start) begin
                    w_state_nx = (sym_total != '0) ? c_S_RUN : c_S_IDLE;
                end
            end
            c_S_RUN: begin
                if (w_err_hit) begin
                    w_state_nx = c_S_ERROR;
                end else if (w_dec && ((r_decoded + CNT_W'(1)) == r_sym_total)) begin
                    w_state_nx = c_S_FLUSH;
                end
            end
            c_S_FLUSH: begin
                if (w_fin) begin
                    w_state_nx = c_S_IDLE;
                end
            end
            default: w_state_nx = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < c_ENTRIES; k++) begin
                r_tbl_len[k]  <= '0;
                r_tbl_code[k] <= '0;
            end
        end else if ((r_state == c_S_IDLE) && cfg_we) begin
            r_tbl_len[cfg_addr]  <= cfg_len;
            r_tbl_code[cfg_addr] <= cfg_code;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_sym_total <= '0;
            r_decoded   <= '0;
            r_pack      <= '0;
            r_pack_cnt  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_fin || (w_start && (sym_total == '0));
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_buf       <= '0;
                r_cnt       <= '0;
                r_decoded   <= '0;
                r_sym_total <= sym_total;
                r_pack      <= '0;
                r_pack_cnt  <= '0;
                r_err       <= 1'b0;
            end else if (w_fin) begin
                r_buf <= '0;
                r_cnt <= '0;
            end else begin
                r_buf      <= w_buf_nx;
                r_cnt      <= w_cnt_nx;
                r_pack     <= w_pack_nx;
                r_pack_cnt <= w_pack_cnt_nx;
                if (w_dec) begin
                    r_decoded <= r_decoded + CNT_W'(1);
                end
            end
        end
    end

    // Output word stays frozen until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lanes <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_pack;
            r_out_lanes <= r_pack_cnt;
            r_out_last  <= (r_state == c_S_FLUSH) || (r_decoded == r_sym_total);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_lanes = r_out_lanes;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != c_S_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/huffman_stream_decoder.md
Name: huffman_stream_decoder

Overview:
Parametrised, table-programmable Huffman decoder that converts a compressed bit stream into packed fixed-width weight symbols. It sits between the compressed-weight SRAM read path and the L0/compute feed. Compared with the fixed-code decoder, it adds:
- a runtime-loadable code table
- generic symbol, input and output widths
- valid/ready backpressure on both sides
- a symbol-count-terminated frame with a partial final output word
- decode-error detection

Parameters:
SYM_W, 4, decoded symbol width; table has 2^SYM_W entries, entry index = symbol value
MAX_LEN, 8, maximum codeword length in bits (1..16)
IN_W, 32, compressed input word width
LANES, 8, symbols packed per output word
CNT_W, 32, width of frame symbol counter

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe; honoured only in IDLE
cfg_addr  in  SYM_W  table entry (symbol) index
cfg_len  in  clog2(MAX_LEN+1)  codeword length; 0 disables entry
cfg_code  in  MAX_LEN  codeword; bit 0 = first transmitted bit
start  in  1  begin frame (IDLE only)
sym_total  in  CNT_W  number of symbols in frame, sampled on start
in_data  in  IN_W  compressed word; in_data[IN_W-1] is first bit in stream
in_valid  in  1  input word valid
in_ready  out  1  decoder accepts word this cycle
out_data  out  LANES*SYM_W  packed symbols; lane i at [i*SYM_W +: SYM_W], lane 0 = earliest
out_lanes  out  clog2(LANES+1)  number of valid lanes in out_data
out_last  out  1  final word of frame
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of frame
err  out  1  sticky decode error

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All table lens = 0.
  - State = IDLE; buffer, count, pack and symbol counters = 0.
  - in_ready=0, out_valid=0, out_data=0, out_lanes=0, out_last=0, busy=0, done=0, err=0.
  - Reset mid-frame discards everything.
- Bit buffer:
  - BUF_W = 2*IN_W bits; stream-first bit held at index 0. count = valid bits, 0..BUF_W.
  - in_ready = (state==RUN) && (count <= BUF_W-IN_W), combinational.
  - Input transfer = in_valid && in_ready. The bit-reversed word is appended at index count (after any same-cycle shift).
- Match rule: entry k matches when:
  - len_k != 0
  - len_k <= count
  - buffer[len_k-1:0] == code_k[len_k-1:0]
  - Lowest k wins on multiple matches; the table is not checked for prefix-freeness.
- Decode, one symbol per cycle, performed when:
  - state==RUN
  - a match exists
  - decoded < sym_total
  - pack slot available (pack not full, or full pack moved to output this cycle)
  - On decode: buffer >>= len; count -= len; symbol written to next pack lane; decoded += 1.
  - Same-cycle shift and append: count' = count - len + IN_W.
- Pack to output:
  - A full pack (LANES symbols) loads the output register when out_valid==0 or out_ready==1, with out_lanes=LANES and out_last = (decoded == sym_total).
  - out_data/out_lanes/out_last are held stable while out_valid && !out_ready.
- Error:
  - Raised in RUN when no entry matches and count >= MAX_LEN.
  - err set, state -> ERROR, in_ready=0.
  - ERROR exits only on start (clears err) or reset.
  - An already-valid output word is still drained.
- States:
  - IDLE: cfg writes accepted.
    - start with sym_total>0: clear buffer, count, decoded and err; -> RUN.
    - start with sym_total==0: done pulses next cycle, stay IDLE, no output.
  - RUN: decode/load.
    - When decoded reaches sym_total -> FLUSH, whether or not a full word shipped this cycle.
  - FLUSH: in_ready=0.
    - If the pack holds 1..LANES-1 symbols, emit it once the output register is free: out_lanes=partial, unused lanes 0, out_last=1.
    - When the last word is accepted (out_valid && out_ready && out_last): done=1 for one cycle, residual buffer bits discarded, -> IDLE.
  - ERROR: described above.
- start or cfg_we outside IDLE is ignored (except start in ERROR).
- Latency: a symbol whose code is fully in the buffer is decoded the cycle after the word is accepted. First out_valid comes LANES decode cycles after the first decode.
- Stall: with no input and no match (count < MAX_LEN), the decoder waits indefinitely in RUN; no error.

Test Plan:
1. Program entry 0 = code 00 (len 2), entry 1 = 011 (len 3, first bits 1,1,0). start with sym_total=16; in_data=0x00000000 -> two words, out_data=0 each, out_lanes=8; second word out_last=1; done pulses; busy falls.
2. Same table, sym_total=3, in_data=0xD8000000 (stream 110 110 00 ...) -> one word, lanes 0..2 = 1,1,0, out_lanes=3, out_last=1; remaining bits discarded.
3. Hold out_ready=0 for 10 cycles during a 32-symbol frame -> out_data stable while held, in_ready drops once buffer full, no symbol lost or duplicated vs. reference model.
4. Table with only entry 0 (00); in_data=0xFFFFFFFF -> err=1 within 2 cycles, in_ready=0; start then clears err.
5. Random prefix-free table (MAX_LEN=8), random in_valid/out_ready gaps, sym_total=1000 -> output matches software model; out_last only on final word.
6. Assert reset_n mid-frame with out_valid=1 -> all outputs 0 and table lens 0 immediately; start with sym_total=0 -> done pulse, no out_valid.
